// File: rtl/inst_encoder_pkg.sv
// Shared definitions for the RV32I instruction encoder: format codes,
// base opcodes, the canonical NOP and the immediate range limits.
package inst_encoder_pkg;

   typedef enum logic [2:0] {
      FMT_R     = 3'd0,
      FMT_I     = 3'd1,
      FMT_S     = 3'd2,
      FMT_B     = 3'd3,
      FMT_U     = 3'd4,
      FMT_J     = 3'd5,
      FMT_SHIFT = 3'd6,
      FMT_BAD   = 3'd7
   } fmt_e;

   localparam logic [6:0] OP_LUI    = 7'h37;
   localparam logic [6:0] OP_AUIPC  = 7'h17;
   localparam logic [6:0] OP_JAL    = 7'h6F;
   localparam logic [6:0] OP_JALR   = 7'h67;
   localparam logic [6:0] OP_BRANCH = 7'h63;
   localparam logic [6:0] OP_LOAD   = 7'h03;
   localparam logic [6:0] OP_STORE  = 7'h23;
   localparam logic [6:0] OP_IMM    = 7'h13;
   localparam logic [6:0] OP_REG    = 7'h33;

   // addi x0, x0, 0
   localparam logic [31:0] NOP_WORD = 32'h0000_0013;

   localparam int IMM12_MIN = -2048;
   localparam int IMM12_MAX = 2047;
   localparam int IMM_B_MIN = -4096;
   localparam int IMM_B_MAX = 4094;
   localparam int IMM_J_MIN = -(1 << 20);
   localparam int IMM_J_MAX = (1 << 20) - 2;

   // Field bundle held in the first pipeline stage.
   typedef struct packed {
      logic [2:0]  fmt;
      logic [6:0]  opcode;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  funct3;
      logic [6:0]  funct7;
      logic [31:0] imm;
   } fields_t;

   // True when the signed immediate lies inside [lo, hi].
   function automatic logic in_range(input logic signed [31:0] v, input int lo, input int hi);
      return (v >= lo) && (v <= hi);
   endfunction

endpackage

// File: rtl/inst_field_packer.sv
// Combinational RV32I packer: places the fields at their architectural bit
// positions and flags immediates that the chosen format cannot represent.
module inst_field_packer
   import inst_encoder_pkg::*;
(
   input  logic [2:0]  fmt,
   input  logic [6:0]  opcode,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [2:0]  funct3,
   input  logic [6:0]  funct7,
   input  logic [31:0] imm,
   output logic [31:0] inst,
   output logic        err
);

   logic signed [31:0] imm_s;
   assign imm_s = imm;

   // Select the packing and range rule for the requested format.
   always_comb begin
      // NOTE: both outputs get a default before the case so no branch can infer a latch.
      inst = NOP_WORD;
      err  = 1'b0;
      case (fmt)
         FMT_R: begin
            inst = {funct7, rs2, rs1, funct3, rd, opcode};
         end
         FMT_I: begin
            inst = {imm[11:0], rs1, funct3, rd, opcode};
            err  = !in_range(imm_s, IMM12_MIN, IMM12_MAX);
         end
         FMT_S: begin
            inst = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            err  = !in_range(imm_s, IMM12_MIN, IMM12_MAX);
         end
         FMT_B: begin
            inst = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            err  = !in_range(imm_s, IMM_B_MIN, IMM_B_MAX) || imm[0];
         end
         FMT_U: begin
            inst = {imm[31:12], rd, opcode};
            err  = (imm[11:0] != 12'd0);
         end
         FMT_J: begin
            inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            err  = !in_range(imm_s, IMM_J_MIN, IMM_J_MAX) || imm[0];
         end
         FMT_SHIFT: begin
            inst = {funct7, imm[4:0], rs1, funct3, rd, opcode};
            err  = (imm[31:5] != 27'd0);
         end
         default: begin
            inst = NOP_WORD;
            err  = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/inst_encoder.sv
// Two-stage elastic encoder: S1 holds the field bundle, S2 holds the packed
// word and its error flag; words leave with a wrapping sequential address.
module inst_encoder
   import inst_encoder_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_fmt,
   input  logic [6:0]        in_opcode,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [2:0]        in_funct3,
   input  logic [6:0]        in_funct7,
   input  logic [31:0]       in_imm,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_inst,
   output logic [ADDR_W-1:0] out_addr,
   output logic              out_err,
   output logic [7:0]        err_count,
   output logic              wrap
);

   fields_t           s1_q, s1_d;
   logic              s1_full_q, s1_full_d;
   logic              s2_full_q, s2_full_d;
   logic [31:0]       s2_inst_q, s2_inst_d;
   logic              s2_err_q, s2_err_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        err_count_q, err_count_d;
   logic              wrap_q, wrap_d;

   logic              s1_load, s2_load, in_fire, out_fire;
   logic [31:0]       pack_inst;
   logic              pack_err;

   // A stage loads when empty or when its contents leave this cycle.
   assign s2_load  = !s2_full_q || out_ready;
   assign s1_load  = !s1_full_q || s2_load;
   assign in_ready = s1_load && !rst;
   assign in_fire  = in_valid && in_ready;
   assign out_fire = s2_full_q && out_ready;

   inst_field_packer u_packer (
      .fmt    (s1_q.fmt),
      .opcode (s1_q.opcode),
      .rd     (s1_q.rd),
      .rs1    (s1_q.rs1),
      .rs2    (s1_q.rs2),
      .funct3 (s1_q.funct3),
      .funct7 (s1_q.funct7),
      .imm    (s1_q.imm),
      .inst   (pack_inst),
      .err    (pack_err)
   );

   // Next state for both stages plus address, wrap and error bookkeeping.
   always_comb begin
      s1_full_d   = s1_full_q;
      s1_d        = s1_q;
      s2_full_d   = s2_full_q;
      s2_inst_d   = s2_inst_q;
      s2_err_d    = s2_err_q;
      addr_d      = addr_q;
      err_count_d = err_count_q;

      if (s1_load) begin
         s1_full_d = in_fire;
      end
      if (in_fire) begin
         s1_d = '{fmt: in_fmt, opcode: in_opcode, rd: in_rd, rs1: in_rs1, rs2: in_rs2,
                  funct3: in_funct3, funct7: in_funct7, imm: in_imm};
      end

      if (s2_load) begin
         s2_full_d = s1_full_q;
         if (s1_full_q) begin
            s2_inst_d = pack_inst;
            s2_err_d  = pack_err;
         end
      end

      if (out_fire) begin
         addr_d = addr_q + 1'b1;
         if (s2_err_q && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
         end
      end
      wrap_d = out_fire && (addr_q == {ADDR_W{1'b1}});
   end

   // State registers; reset empties the pipeline and clears every output.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: payload registers are reset as well so out_inst reads zero after reset.
         s1_full_q   <= 1'b0;
         s1_q        <= '0;
         s2_full_q   <= 1'b0;
         s2_inst_q   <= '0;
         s2_err_q    <= 1'b0;
         addr_q      <= '0;
         err_count_q <= '0;
         wrap_q      <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         s1_full_q   <= s1_full_d;
         s1_q        <= s1_d;
         s2_full_q   <= s2_full_d;
         s2_inst_q   <= s2_inst_d;
         s2_err_q    <= s2_err_d;
         addr_q      <= addr_d;
         err_count_q <= err_count_d;
         wrap_q      <= wrap_d;
      end
   end

   assign out_valid = s2_full_q;
   assign out_inst  = s2_inst_q;
   assign out_err   = s2_err_q;
   assign out_addr  = addr_q;
   assign err_count = err_count_q;
   assign wrap      = wrap_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Bench for inst_encoder: directed RV32I vectors plus randomized bundles
// checked against an arithmetic reference encoder and a handoff scoreboard.
module tb_inst_encoder;
   import inst_encoder_pkg::*;

   typedef struct {
      logic [2:0]  fmt;
      logic [6:0]  op;
      logic [4:0]  rd, rs1, rs2;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] imm;
   } fld_t;

   typedef struct {
      logic [31:0] inst;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b1;
   logic [2:0]  in_fmt = '0;
   logic [6:0]  in_opcode = '0;
   logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
   logic [2:0]  in_funct3 = '0;
   logic [6:0]  in_funct7 = '0;
   logic [31:0] in_imm = '0;

   logic        in_ready, out_valid, out_err, wrap;
   logic [31:0] out_inst;
   logic [7:0]  out_addr, err_count;
   logic        in_ready_w, out_valid_w, out_err_w, wrap_w;
   logic [31:0] out_inst_w;
   logic [1:0]  out_addr_w;
   logic [7:0]  err_count_w;

   int   n_vec = 0;
   int   n_mis = 0;
   exp_t q[$];
   int   hs_cnt = 0;
   int   m_errs = 0;
   logic m_wrap8 = 1'b0, m_wrap2 = 1'b0, held = 1'b0;
   logic stim_done;

   logic [6:0] ops [9] = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
                           OP_LOAD, OP_STORE, OP_IMM, OP_REG};
   int bounds [16] = '{-2049, -2048, 2047, 2048, -4097, -4096, 4094, 4095,
                       4096, -1048577, -1048576, 1048574, 1048575, 1048576, 31, 32};

   always #5 clk = ~clk;

   inst_encoder #(.ADDR_W(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
      .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
      .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
      .out_addr(out_addr), .out_err(out_err), .err_count(err_count), .wrap(wrap)
   );

   inst_encoder #(.ADDR_W(2)) dut_w (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
      .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
      .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
      .out_valid(out_valid_w), .out_ready(out_ready), .out_inst(out_inst_w),
      .out_addr(out_addr_w), .out_err(out_err_w), .err_count(err_count_w), .wrap(wrap_w)
   );

   task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference encoder built from shifts and masks of the field values.
   function automatic exp_t model(input fld_t f);
      exp_t        e;
      longint      s;
      logic [31:0] u, rd, rs1, rs2, f3, f7, op, base;
      u    = f.imm;
      s    = longint'($signed(f.imm));
      rd   = 32'(f.rd);
      rs1  = 32'(f.rs1);
      rs2  = 32'(f.rs2);
      f3   = 32'(f.f3);
      f7   = 32'(f.f7);
      op   = 32'(f.op);
      base = (f3 << 12) | op;
      e.err = 1'b0;
      case (f.fmt)
         3'd0: e.inst = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | base | (rd << 7);
         3'd1: begin
            e.inst = ((u & 32'hFFF) << 20) | (rs1 << 15) | base | (rd << 7);
            e.err  = (s < -2048) || (s > 2047);
         end
         3'd2: begin
            e.inst = (((u >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | base | ((u & 32'h1F) << 7);
            e.err  = (s < -2048) || (s > 2047);
         end
         3'd3: begin
            e.inst = (((u >> 12) & 32'h1) << 31) | (((u >> 5) & 32'h3F) << 25) | (rs2 << 20) | (rs1 << 15)
                   | base | (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 32'h1) << 7);
            e.err  = (s < -4096) || (s > 4094) || ((u & 32'h1) != 0);
         end
         3'd4: begin
            e.inst = (u & 32'hFFFFF000) | (rd << 7) | op;
            e.err  = (u & 32'hFFF) != 0;
         end
         3'd5: begin
            e.inst = (((u >> 20) & 32'h1) << 31) | (((u >> 1) & 32'h3FF) << 21) | (((u >> 11) & 32'h1) << 20)
                   | (((u >> 12) & 32'hFF) << 12) | (rd << 7) | op;
            e.err  = (s < -1048576) || (s > 1048574) || ((u & 32'h1) != 0);
         end
         3'd6: begin
            e.inst = (f7 << 25) | ((u & 32'h1F) << 20) | (rs1 << 15) | base | (rd << 7);
            e.err  = (u >> 5) != 0;
         end
         default: begin
            e.inst = 32'h0000_0013;
            e.err  = 1'b1;
         end
      endcase
      return e;
   endfunction

   function automatic fld_t mk(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                               input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                               input logic [6:0] f7, input logic [31:0] imm);
      fld_t f;
      f.fmt = fmt; f.op = op; f.rd = rd; f.rs1 = rs1; f.rs2 = rs2;
      f.f3 = f3; f.f7 = f7; f.imm = imm;
      return f;
   endfunction

   function automatic fld_t rand_fld();
      fld_t f;
      f.fmt = 3'($urandom_range(0, 7));
      f.op  = ops[$urandom_range(0, 8)];
      f.rd  = 5'($urandom);
      f.rs1 = 5'($urandom);
      f.rs2 = 5'($urandom);
      f.f3  = 3'($urandom);
      f.f7  = 7'($urandom);
      case ($urandom_range(0, 4))
         0:       f.imm = $urandom;
         1:       f.imm = 32'($urandom_range(0, 10000)) - 32'd5000;
         2:       f.imm = 32'(bounds[$urandom_range(0, 15)]);
         3:       f.imm = $urandom & 32'hFFFFF000;
         default: f.imm = 32'($urandom_range(0, 31));
      endcase
      return f;
   endfunction

   task automatic drive(input fld_t f);
      in_valid  = 1'b1;
      in_fmt    = f.fmt;
      in_opcode = f.op;
      in_rd     = f.rd;
      in_rs1    = f.rs1;
      in_rs2    = f.rs2;
      in_funct3 = f.f3;
      in_funct7 = f.f7;
      in_imm    = f.imm;
   endtask

   // Wait (bounded) for the offered bundle to be taken, then log its expected word.
   task automatic wait_accept(input exp_t e, output int waits);
      waits = 0;
      @(negedge clk);
      while (!in_ready && waits < 64) begin
         waits++;
         @(negedge clk);
      end
      check("accept_in_time", in_ready, 1'b1);
      if (in_ready) begin
         check("in_ready_w", in_ready_w, 1'b1);
         q.push_back(e);
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic send(input fld_t f, input exp_t e, output int waits);
      drive(f);
      wait_accept(e, waits);
   endtask

   task automatic drain();
      int n = 0;
      out_ready = 1'b1;
      do begin
         @(negedge clk);
         n++;
      end while ((out_valid || q.size() != 0) && n < 300);
      check("drain_empty", 33'(q.size()), 33'd0);
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: every handoff is compared with the oldest expected word.
   always @(negedge clk) begin
      if (rst) begin
         q.delete();
         hs_cnt  = 0;
         m_errs  = 0;
         m_wrap8 = 1'b0;
         m_wrap2 = 1'b0;
         held    = 1'b0;
      end else begin
         check("out_addr", 33'(out_addr), 33'(hs_cnt % 256));
         check("out_addr_w", 33'(out_addr_w), 33'(hs_cnt % 4));
         check("err_count", 33'(err_count), 33'(m_errs));
         check("err_count_w", 33'(err_count_w), 33'(m_errs));
         check("wrap", wrap, m_wrap8);
         check("wrap_w", wrap_w, m_wrap2);
         if (held) check("hold_valid", out_valid, 1'b1);
         held    = out_valid && !out_ready;
         m_wrap8 = 1'b0;
         m_wrap2 = 1'b0;
         if (out_valid) begin
            if (q.size() == 0) begin
               check("spurious_valid", out_valid, 1'b0);
            end else begin
               check("out_inst", out_inst, q[0].inst);
               check("out_err", out_err, q[0].err);
               check("out_valid_w", out_valid_w, 1'b1);
               check("out_inst_w", out_inst_w, q[0].inst);
               check("out_err_w", out_err_w, q[0].err);
               if (out_ready) begin
                  m_wrap8 = (hs_cnt % 256) == 255;
                  m_wrap2 = (hs_cnt % 4) == 3;
                  if (q[0].err && m_errs < 255) m_errs++;
                  hs_cnt++;
                  void'(q.pop_front());
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      fld_t f;
      exp_t e;
      int   w;

      // Reset state.
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_inst", out_inst, 32'h0);
      check("rst_out_addr", 33'(out_addr), 33'd0);
      check("rst_out_err", out_err, 1'b0);
      check("rst_err_count", 33'(err_count), 33'd0);
      check("rst_wrap", wrap, 1'b0);
      check("rst_in_ready", in_ready, 1'b0);
      @(posedge clk);
      #1 rst = 1'b0;

      // Latency: accepted in cycle N, visible in cycle N+2.
      send(mk(FMT_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5), '{32'h0050_0093, 1'b0}, w);
      check("lat_no_stall", 33'(w), 33'd0);
      @(negedge clk);
      check("lat_n1_valid", out_valid, 1'b0);
      @(posedge clk);
      #1 check("lat_n2_valid", out_valid, 1'b1);

      // Back-to-back, one word per cycle.
      send(mk(FMT_S, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8), '{32'h0020_A423, 1'b0}, w);
      check("b2b_s", 33'(w), 33'd0);
      send(mk(FMT_B, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd4), '{32'hFE00_0EE3, 1'b0}, w);
      check("b2b_b", 33'(w), 33'd0);
      send(mk(FMT_J, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8), '{32'h0080_00EF, 1'b0}, w);
      check("b2b_j", 33'(w), 33'd0);
      send(mk(FMT_SHIFT, 7'h13, 5'd5, 5'd5, 5'd0, 3'd5, 7'h20, 32'd3), '{32'h4032_D293, 1'b0}, w);
      check("b2b_shift", 33'(w), 33'd0);

      // Error cases.
      f = mk(FMT_B, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3);
      e = model(f); e.err = 1'b1;
      send(f, e, w);
      f = mk(FMT_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
      e = model(f); e.err = 1'b1;
      send(f, e, w);
      send(mk(FMT_BAD, 7'h33, 5'd9, 5'd9, 5'd9, 3'd7, 7'h7F, 32'hDEAD_BEEF), '{32'h0000_0013, 1'b1}, w);
      drain();
      check("err_count_3", 33'(err_count), 33'd3);
      check("addr_after_8", 33'(out_addr), 33'd8);

      // Backpressure: two bundles fill the pipe, the third waits.
      out_ready = 1'b0;
      send(mk(FMT_I, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF), '{32'hFFF0_0193, 1'b0}, w);
      send(mk(FMT_U, 7'h37, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000), '{32'h1234_5237, 1'b0}, w);
      check("bp_second_taken", 33'(w), 33'd0);
      drive(mk(FMT_R, 7'h33, 5'd5, 5'd6, 5'd7, 3'd0, 7'd0, 32'h5555_5555));
      repeat (3) begin
         @(negedge clk);
         check("bp_in_ready", in_ready, 1'b0);
         check("bp_out_valid", out_valid, 1'b1);
         check("bp_out_inst", out_inst, 32'hFFF0_0193);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      wait_accept('{32'h0073_02B3, 1'b0}, w);
      drain();
      check("bp_addr_11", 33'(out_addr), 33'd11);

      // Randomized bundles with random backpressure and idle gaps.
      stim_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 200; i++) begin
               f = rand_fld();
               send(f, model(f), w);
               repeat ($urandom_range(0, 1)) begin
                  @(posedge clk);
                  #1;
               end
            end
            stim_done = 1'b1;
         end
         begin
            while (!stim_done) begin
               @(posedge clk);
               #1 out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      drain();

      // Saturation of the error counter.
      for (int i = 0; i < 300; i++) begin
         send(mk(FMT_BAD, 7'($urandom), 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, $urandom), '{32'h0000_0013, 1'b1}, w);
      end
      drain();
      check("err_count_sat", 33'(err_count), 33'd255);
      check("err_count_sat_w", 33'(err_count_w), 33'd255);

      // Asynchronous reset with both stages full.
      out_ready = 1'b0;
      send(mk(FMT_I, 7'h13, 5'd2, 5'd2, 5'd0, 3'd0, 7'd0, 32'd1), model(mk(FMT_I, 7'h13, 5'd2, 5'd2, 5'd0, 3'd0, 7'd0, 32'd1)), w);
      send(mk(FMT_U, 7'h17, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_1000), '{32'h0000_1117, 1'b0}, w);
      @(negedge clk);
      check("pre_rst_full", out_valid, 1'b1);
      #2 rst = 1'b1;
      #1;
      check("arst_out_valid", out_valid, 1'b0);
      check("arst_out_addr", 33'(out_addr), 33'd0);
      check("arst_err_count", 33'(err_count), 33'd0);
      check("arst_out_inst", out_inst, 32'h0);
      check("arst_in_ready", in_ready, 1'b0);
      @(negedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      out_ready = 1'b1;
      send(mk(FMT_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5), '{32'h0050_0093, 1'b0}, w);
      @(posedge clk);
      #1 check("post_rst_valid", out_valid, 1'b1);
      check("post_rst_addr", 33'(out_addr), 33'd0);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
Inverse of the decode-side immediate generator. Accepts RV32I instruction fields (format, opcode, registers, funct fields, full 32-bit signed immediate) over a valid/ready handshake, range-checks the immediate, packs the 32-bit instruction word and emits it with a sequential word address. Used by the self-test program loader to build instruction-memory images in hardware. The output stream feeds the imem write port.

Parameters:
ADDR_W, 8, width of the emitted word address; the address wraps at 2^ADDR_W.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  field bundle valid
in_ready  out  1  encoder can accept the bundle this cycle
in_fmt  in  3  0=R 1=I 2=S 3=B 4=U 5=J 6=SHIFT; 7 is illegal
in_opcode  in  7  inst[6:0]
in_rd  in  5  destination register
in_rs1  in  5  source register 1
in_rs2  in  5  source register 2
in_funct3  in  3  inst[14:12]
in_funct7  in  7  inst[31:25] (R and SHIFT only)
in_imm  in  32  signed byte-offset or immediate value
out_valid  out  1  encoded word valid
out_ready  in  1  sink accepts the word
out_inst  out  32  encoded instruction
out_addr  out  ADDR_W  word index of out_inst
out_err  out  1  immediate out of range or illegal fmt, qualified by out_valid
err_count  out  8  saturating count of errored words handed off
wrap  out  1  one-cycle pulse after the handoff at address 2^ADDR_W-1

Behaviour:
- Reset (async, any cycle, including mid-stream): both stages empty; out_valid=0, out_inst=0, out_addr=0, out_err=0, err_count=0, wrap=0. Any in-flight words are discarded. in_ready=0 while rst=1.
- Two-stage elastic pipeline: S1 registers the input bundle; S2 registers the packed word and error flag, which drive the out_* ports.
- A stage loads when it is empty or its contents move downstream in the same cycle. in_ready = !S1_full || (S2 loads this cycle), so the full chain can be combinational.
- Latency: a bundle accepted in cycle N appears on out_* in cycle N+2. Throughput is one word per cycle with out_ready=1. No loss and no duplication under backpressure. While out_valid=1 and out_ready=0, out_* stay stable.
- Handshake: a transfer occurs when valid && ready. Bundles, words and error flags are never dropped or reordered.
- Packing (fields placed at standard RV32I bit positions):
  - R: {funct7, rs2, rs1, f3, rd, op}.
  - I: {imm[11:0], rs1, f3, rd, op}.
  - S: {imm[11:5], rs2, rs1, f3, imm[4:0], op}.
  - B: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op}.
  - U: {imm[31:12], rd, op}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}.
  - SHIFT: {funct7, imm[4:0], rs1, f3, rd, op}.
- Errors (word is still emitted with out_err=1):
  - I, S: imm outside [-2048, 2047].
  - B: imm outside [-4096, 4094], or imm[0]=1.
  - J: imm outside [-2^20, 2^20-2], or imm[0]=1.
  - U: imm[11:0] != 0.
  - SHIFT: imm[31:5] != 0.
  - fmt=7: out_inst=0x00000013 (NOP).
  - R: never errors; in_imm is ignored.
- Address: out_addr increments by 1 on each output handshake and wraps from 2^ADDR_W-1 to 0. wrap pulses in the cycle after the handoff at the maximum address.
- err_count increments on each handshake with out_err=1 and saturates at 255.

Decomposition:
- Shared package: fmt encodings (FMT_R..FMT_SHIFT), RV32I opcode constants, NOP word 32'h00000013, immediate range limits.
- One sub-module, inst_field_packer: purely combinational packing and range checking, instantiated between S1 and S2.

Test Plan:
- I fmt, op=0x13, rd=1, rs1=0, f3=0, imm=5 -> out_inst=0x00500093, out_addr=0, out_err=0, out_valid exactly 2 cycles after accept.
- Back-to-back with out_ready=1: S fmt sw x2,8(x1) -> 0x0020A423; B fmt beq x0,x0,-4 -> 0xFE000EE3; J fmt jal x1,8 -> 0x008000EF; SHIFT srai x5,x5,3 with funct7=0x20 -> 0x4032D293; addresses 0-3 in order.
- Errors: B imm=3 -> out_err=1; I imm=2048 -> out_err=1; fmt=7 -> out_inst=0x00000013, out_err=1; err_count=3 after handoff; 300 errored words -> err_count=255.
- Backpressure: out_ready=0 while 3 bundles are offered -> 2 accepted then in_ready=0, out_inst held stable; release -> 3 words, addresses 0,1,2, none lost.
- ADDR_W=2, 5 words -> out_addr 0,1,2,3,0; wrap high exactly one cycle, after the 4th handoff.
- rst asserted with both stages full -> out_valid=0, out_addr=0 and err_count=0 immediately (asynchronous); first word after release is at address 0.
